alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 119 +++++++++++
 tb/tb_alu_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU sequencer: reads two registers, executes one op, writes the result back.
// Each instruction moves through IDLE -> READ -> EXEC -> WRITE, one cycle per state.
module alu_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  input  logic [DATA_W-1:0] imm,
  output logic [ADDR_W-1:0] ra1,
  output logic [ADDR_W-1:0] ra2,
  input  logic [DATA_W-1:0] rd1,
  input  logic [DATA_W-1:0] rd2,
  output logic              we3,
  output logic [ADDR_W-1:0] wa3,
  output logic [DATA_W-1:0] wd3,
  output logic              done,
  output logic              zero,
  output logic              carry
);

  typedef enum logic [1:0] {StIdle, StRead, StExec, StWrite} state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q;
  logic [ADDR_W-1:0]   dst_q, ra1_q, ra2_q;
  logic [DATA_W-1:0]   imm_q, a_q, b_q, res_q, res_d;
  logic                zero_q, carry_q, carry_d;
  logic                accept;

  assign accept = in_valid && (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRead;
      StRead:  state_d = StExec;
      StExec:  state_d = StWrite;
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    case (op_q)
      3'b000: {carry_d, res_d} = {1'b0, a_q} + {1'b0, b_q};
      3'b001: begin
        res_d   = a_q - b_q;
        carry_d = (a_q < b_q);
      end
      3'b010: res_d = a_q & b_q;
      3'b011: res_d = a_q | b_q;
      3'b100: res_d = a_q ^ b_q;
      3'b101: begin
        res_d   = {a_q[DATA_W-2:0], 1'b0};
        carry_d = a_q[DATA_W-1];
      end
      3'b110: begin
        res_d   = {1'b0, a_q[DATA_W-1:1]};
        carry_d = a_q[0];
      end
      default: res_d = imm_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      dst_q   <= '0;
      imm_q   <= '0;
      ra1_q   <= '0;
      ra2_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= op;
        dst_q <= dst;
        imm_q <= imm;
        ra1_q <= src1;
        ra2_q <= src2;
      end
      // Operands are captured before WRITE, so dst may alias a source.
      if (state_q == StRead) begin
        a_q <= rd1;
        b_q <= rd2;
      end
      if (state_q == StExec) begin
        res_q   <= res_d;
        zero_q  <= (res_d == '0);
        carry_q <= carry_d;
      end
    end
  end

  assign in_ready = (state_q == StIdle);
  assign we3      = (state_q == StWrite);
  assign done     = (state_q == StWrite);
  assign ra1      = ra1_q;
  assign ra2      = ra2_q;
  assign wa3      = dst_q;
  assign wd3      = res_q;
  assign zero     = zero_q;
  assign carry    = carry_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 8x8 register file.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] op = '0;
  logic [2:0] dst = '0, src1 = '0, src2 = '0;
  logic [7:0] imm = '0;
  logic [2:0] ra1, ra2, wa3;
  logic [7:0] rd1, rd2, wd3;
  logic       we3, done, zero, carry;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int acc_n = 0;
  int acc_t [64];

  logic [7:0] rf [8];

  always #5 clk = ~clk;

  alu_sequencer #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .dst(dst), .src1(src1), .src2(src2), .imm(imm),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we3(we3), .wa3(wa3), .wd3(wd3), .done(done), .zero(zero), .carry(carry)
  );

  assign rd1 = rf[ra1];
  assign rd2 = rf[ra2];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (we3) rf[wa3] <= wd3;
    if (done) done_cnt <= done_cnt + 1;
    if (rst_n && in_valid && in_ready) begin
      acc_t[acc_n % 64] <= cyc;
      acc_n <= acc_n + 1;
    end
  end

  typedef struct {
    logic [2:0] op, dst, s1, s2;
    logic [7:0] imm, exp_wd3;
    logic       exp_z, exp_c;
  } vec_t;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND = 3'd2, OR = 3'd3;
  localparam logic [2:0] XOR = 3'd4, SHL = 3'd5, SHR = 3'd6, MOVI = 3'd7;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    op = v.op; dst = v.dst; src1 = v.s1; src2 = v.s2; imm = v.imm;
  endtask

  // Issue one instruction from a negedge and check its write-back cycle.
  task automatic issue(input vec_t v, input string tag);
    int guard = 0;
    int lat = 0;
    @(negedge clk);
    drive(v);
    in_valid = 1'b1;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " accept"}, (guard < 20), 1);
    @(posedge clk);
    do begin
      @(negedge clk);
      if (lat == 0) in_valid = 1'b0;
      lat++;
    end while (!done && lat < 8);
    check({tag, " latency"}, lat, 3);
    check({tag, " we3"}, we3, 1'b1);
    check({tag, " wa3"}, wa3, v.dst);
    check({tag, " wd3"}, wd3, v.exp_wd3);
    check({tag, " zero"}, zero, v.exp_z);
    check({tag, " carry"}, carry, v.exp_c);
    check({tag, " ra1"}, ra1, v.s1);
    check({tag, " ra2"}, ra2, v.s2);
  endtask

  vec_t vecs [14];

  initial begin
    int base;
    int d0;
    vecs[0]  = '{MOVI, 3'd1, 3'd0, 3'd0, 8'h30, 8'h30, 1'b0, 1'b0};
    vecs[1]  = '{MOVI, 3'd1, 3'd0, 3'd0, 8'hF0, 8'hF0, 1'b0, 1'b0};
    vecs[2]  = '{MOVI, 3'd2, 3'd0, 3'd0, 8'h20, 8'h20, 1'b0, 1'b0};
    vecs[3]  = '{ADD,  3'd3, 3'd1, 3'd2, 8'h00, 8'h10, 1'b0, 1'b1};
    vecs[4]  = '{SUB,  3'd4, 3'd1, 3'd1, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[5]  = '{SUB,  3'd6, 3'd2, 3'd1, 8'h00, 8'h30, 1'b0, 1'b1};
    vecs[6]  = '{AND,  3'd7, 3'd1, 3'd2, 8'h00, 8'h20, 1'b0, 1'b0};
    vecs[7]  = '{OR,   3'd7, 3'd1, 3'd3, 8'h00, 8'hF0, 1'b0, 1'b0};
    vecs[8]  = '{XOR,  3'd7, 3'd1, 3'd1, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[9]  = '{MOVI, 3'd5, 3'd0, 3'd0, 8'h81, 8'h81, 1'b0, 1'b0};
    vecs[10] = '{SHL,  3'd5, 3'd5, 3'd0, 8'h00, 8'h02, 1'b0, 1'b1};
    vecs[11] = '{SHR,  3'd5, 3'd5, 3'd0, 8'h00, 8'h01, 1'b0, 1'b0};
    vecs[12] = '{XOR,  3'd0, 3'd3, 3'd6, 8'h00, 8'h20, 1'b0, 1'b0};
    vecs[13] = '{ADD,  3'd0, 3'd0, 3'd0, 8'h00, 8'h40, 1'b0, 1'b0};

    // Reset state, with an instruction offered that must be ignored.
    drive('{MOVI, 3'd7, 3'd0, 3'd0, 8'hFF, 8'h00, 1'b0, 1'b0});
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst we3", we3, 1'b0);
    check("rst done", done, 1'b0);
    check("rst ra1", ra1, 3'd0);
    check("rst ra2", ra2, 3'd0);
    check("rst wa3", wa3, 3'd0);
    check("rst wd3", wd3, 8'h00);
    check("rst flags", {zero, carry}, 2'b00);
    check("rst in_ready", in_ready, 1'b1);
    in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst no write", done_cnt, 0);

    foreach (vecs[i]) issue(vecs[i], $sformatf("vec%0d", i));

    // Three queued instructions with in_valid held high.
    @(negedge clk);
    base = acc_n;
    d0 = done_cnt;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) drive('{MOVI, 3'd1, 3'd0, 3'd0, 8'h11, 8'h0, 1'b0, 1'b0});
      if (k == 1) drive('{MOVI, 3'd2, 3'd0, 3'd0, 8'h22, 8'h0, 1'b0, 1'b0});
      if (k == 2) drive('{ADD,  3'd3, 3'd1, 3'd2, 8'h00, 8'h0, 1'b0, 1'b0});
      check($sformatf("q%0d ready", k), in_ready, 1'b1);
      for (int j = 1; j <= 3; j++) begin
        @(negedge clk);
        check($sformatf("q%0d busy%0d", k, j), in_ready, 1'b0);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("q accepts", acc_n - base, 3);
    check("q gap01", acc_t[(base + 1) % 64] - acc_t[base % 64], 4);
    check("q gap12", acc_t[(base + 2) % 64] - acc_t[(base + 1) % 64], 4);
    check("q dones", done_cnt - d0, 3);
    check("q r3", rf[3], 8'h33);

    // Reset during EXEC aborts the ADD.
    issue('{SUB, 3'd4, 3'd1, 3'd1, 8'h00, 8'h00, 1'b1, 1'b0}, "presub");
    @(negedge clk);
    drive('{ADD, 3'd7, 3'd1, 3'd2, 8'h00, 8'h0, 1'b0, 1'b0});
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("abort we3", we3, 1'b0);
    check("abort done", done, 1'b0);
    check("abort flags", {zero, carry}, 2'b00);
    check("abort ra1", ra1, 3'd0);
    check("abort in_ready", in_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort no write", done_cnt - d0, 0);
    check("abort r7", rf[7], 8'h00);
    issue('{MOVI, 3'd6, 3'd0, 3'd0, 8'h5A, 8'h5A, 1'b0, 1'b0}, "post");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
